uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  UART receive controller: frame FSM plus 3-sample majority data sampler and deserializer.
//  Drives the enable of the edge/bit counter stage and consumes its edge_cnt/bit_cnt outputs.
//  Outputs the received byte with a 1-cycle valid strobe, and flags parity and stop errors.
//  Sits between the RX pin synchronizer and the RX-side data synchronizer (CDC) stage.
// PARAMETERS
//  DATA_WIDTH   8   payload bits per frame, LSB first
//  PRESC_WIDTH  6   width of Prescale and edge_cnt
//  BIT_CNT_W    4   width of bit_cnt
// PORTS
//  CLK         in   1            RX oversampling clock
//  RST         in   1            reset, asynchronous, active-low
//  RX_IN       in   1            serial line, already synchronized to CLK, idle high
//  PAR_EN      in   1            1 = frame carries a parity bit
//  PAR_TYP     in   1            0 = even, 1 = odd parity
//  Prescale    in   PRESC_WIDTH  oversampling ratio; legal values 8, 16, 32
//  edge_cnt    in   PRESC_WIDTH  edge index within current bit, 0..Prescale-1
//  bit_cnt     in   BIT_CNT_W    bit index within frame, 0 = start bit
//  cnt_enable  out  1            run counter stage; counters hold 0 while low
//  P_DATA      out  DATA_WIDTH   last good received word
//  data_valid  out  1            1-cycle strobe, P_DATA updated on the same edge
//  par_err     out  1            parity mismatch of current/last frame
//  stp_err     out  1            stop bit sampled 0 in current/last frame
//  busy        out  1            high in every state except IDLE
//  err_cnt     out  8            only with UART_RX_ERR_CNT_EN
// BEHAVIOUR
//  Reset: state=IDLE; cnt_enable, data_valid, par_err, stp_err, busy = 0; P_DATA = 0; shift reg = 0.
//  Reset mid-frame aborts immediately. No partial word is ever presented.
//  Counter contract: while cnt_enable=1, edge_cnt increments each CLK.
//   It wraps from Prescale-1 to 0 and increments bit_cnt at the wrap.
//  Sampler: RX_IN captured at edge_cnt = Prescale/2-1, Prescale/2, Prescale/2+1.
//   sampled_bit = majority(3), registered at edge_cnt = Prescale/2+1.
//  Bit decision point (end_of_bit): edge_cnt == Prescale-1.
//  States:
//   IDLE:   cnt_enable=0. RX_IN==0 -> START, with cnt_enable=1 from the next cycle.
//   START:  at end_of_bit, sampled_bit==1 -> glitch: IDLE, cnt_enable=0, no flags.
//           Otherwise -> DATA; par_err and stp_err cleared here.
//   DATA:   at end_of_bit, shift sampled_bit in LSB-first.
//           When bit_cnt==DATA_WIDTH -> PARITY if PAR_EN, else STOP.
//   PARITY: at end_of_bit, par_err = sampled_bit != (^shift ^ PAR_TYP). -> STOP.
//   STOP:   at end_of_bit, stp_err = ~sampled_bit.
//           If no error: P_DATA<=shift and data_valid=1 for exactly 1 cycle. -> IDLE.
//  Error frame: P_DATA is held, no data_valid; flags stay until the next valid START.
//  Back-to-back frames: a start edge in the cycle after STOP exit is accepted (1-cycle IDLE).
//  Latency: data_valid asserts on the CLK after the stop-bit end_of_bit edge.
//  PAR_EN, PAR_TYP and Prescale must be stable while busy=1; changes mid-frame are unsupported.
//  Illegal Prescale: behaviour undefined, no protection logic.
// CONFIGURATION
//  UART_RX_ERR_CNT_EN defined:
//   err_cnt is an 8-bit saturating counter (holds at 255).
//   It increments once per frame ending with par_err or stp_err (glitches not counted).
//   Reset to 0 by RST only.
//  Undefined: no err_cnt port, no counter logic.
// TESTING
//  Presc=8, PAR_EN=0, send 0xA5 -> data_valid 1 cycle, P_DATA=0xA5, no error flags.
//  Presc=16, PAR_EN=1, PAR_TYP=0, 0x3C with parity 0 -> P_DATA=0x3C, par_err=0.
//   Same frame with parity 1 -> par_err=1, no data_valid, P_DATA keeps its old value.
//  Presc=32, 0x81 sent with stop bit 0 -> stp_err=1, no data_valid.
//   Next good frame 0x55 -> flags clear at START, P_DATA=0x55.
//  RX_IN low for Prescale/2-2 cycles then high -> back to IDLE, cnt_enable=0, no flags.
//  RST asserted during DATA -> all outputs 0 asynchronously; next frame 0x0F received OK.
//  Two back-to-back frames 0x12,0x34 at Presc=8 -> two data_valid strobes, in order.
//   Single-sample glitch at mid-bit is rejected by the majority vote.
//  With UART_RX_ERR_CNT_EN: 300 parity-error frames -> err_cnt=255.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// Output bundle of the UART receive controller toward the RX-side data synchronizer.
// The controller drives it through the master modport and the consumer reads it through the slave modport.
interface uart_rx_ctrl_if #(
   parameter int DATA_WIDTH = 8
);

   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  data_valid;
   logic                  par_err;
   logic                  stp_err;
   logic                  busy;

   modport master (
      output P_DATA,
      output data_valid,
      output par_err,
      output stp_err,
      output busy
   );

   modport slave (
      input P_DATA,
      input data_valid,
      input par_err,
      input stp_err,
      input busy
   );

endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, 3-sample majority sampler and LSB-first deserializer.
// Optional saturating error-frame counter on port err_cnt when UART_RX_ERR_CNT_EN is defined.
module uart_rx_ctrl #(
   parameter int DATA_WIDTH  = 8,
   parameter int PRESC_WIDTH = 6,
   parameter int BIT_CNT_W   = 4
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   RX_IN,
   input  logic                   PAR_EN,
   input  logic                   PAR_TYP,
   input  logic [PRESC_WIDTH-1:0] Prescale,
   input  logic [PRESC_WIDTH-1:0] edge_cnt,
   input  logic [BIT_CNT_W-1:0]   bit_cnt,
   output logic                   cnt_enable,
`ifdef UART_RX_ERR_CNT_EN
   output logic [7:0]             err_cnt,
`endif
   uart_rx_ctrl_if.master         rx_out
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t state;
   state_t next_state;

   logic [PRESC_WIDTH-1:0] half_edge;
   logic [PRESC_WIDTH-1:0] early_edge;
   logic [PRESC_WIDTH-1:0] late_edge;
   logic [PRESC_WIDTH-1:0] last_edge;
   logic                   end_of_bit;
   logic                   last_data_bit;

   logic                   smp_early;
   logic                   smp_mid;
   logic                   sampled_bit;

   logic [DATA_WIDTH-1:0]  shift_reg;
   logic [DATA_WIDTH-1:0]  p_data;
   logic                   data_valid;
   logic                   par_err;
   logic                   stp_err;

   assign half_edge     = Prescale >> 1;
   assign early_edge    = half_edge - PRESC_WIDTH'(1);
   assign late_edge     = half_edge + PRESC_WIDTH'(1);
   assign last_edge     = Prescale - PRESC_WIDTH'(1);
   assign end_of_bit    = (edge_cnt == last_edge);
   assign last_data_bit = (bit_cnt == BIT_CNT_W'(DATA_WIDTH));

   // Counter stage runs for the whole frame; it is held cleared while idle.
   assign cnt_enable = (state != IDLE);

   assign rx_out.P_DATA     = p_data;
   assign rx_out.data_valid = data_valid;
   assign rx_out.par_err    = par_err;
   assign rx_out.stp_err    = stp_err;
   assign rx_out.busy       = (state != IDLE);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (!RX_IN) begin
               next_state = START;
            end
         end
         START: begin
            if (end_of_bit) begin
               next_state = sampled_bit ? IDLE : DATA;
            end
         end
         DATA: begin
            if (end_of_bit && last_data_bit) begin
               next_state = PAR_EN ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (end_of_bit) begin
               next_state = STOP;
            end
         end
         STOP: begin
            if (end_of_bit) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Three samples around mid-bit; the vote is registered on the last one so it is settled before end_of_bit.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         smp_early   <= 1'b0;
         smp_mid     <= 1'b0;
         sampled_bit <= 1'b0;
      end else if (state != IDLE) begin
         if (edge_cnt == early_edge) begin
            smp_early <= RX_IN;
         end
         if (edge_cnt == half_edge) begin
            smp_mid <= RX_IN;
         end
         if (edge_cnt == late_edge) begin
            sampled_bit <= (smp_early & smp_mid) | (smp_early & RX_IN) | (smp_mid & RX_IN);
         end
      end
   end

   // Deserializer and flags; P_DATA only moves on a clean frame, together with the valid strobe.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         shift_reg  <= '0;
         p_data     <= '0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         case (state)
            START: begin
               if (end_of_bit && !sampled_bit) begin
                  par_err <= 1'b0;
                  stp_err <= 1'b0;
               end
            end
            DATA: begin
               if (end_of_bit) begin
                  shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
               end
            end
            PARITY: begin
               if (end_of_bit) begin
                  par_err <= (sampled_bit != ((^shift_reg) ^ PAR_TYP));
               end
            end
            STOP: begin
               if (end_of_bit) begin
                  stp_err <= ~sampled_bit;
                  if (sampled_bit && !par_err) begin
                     p_data     <= shift_reg;
                     data_valid <= 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef UART_RX_ERR_CNT_EN
   // One count per completed frame that ends with either flag set; glitch aborts never reach STOP.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         err_cnt <= 8'd0;
      end else if ((state == STOP) && end_of_bit && (!sampled_bit || par_err) && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: bit-level frame driver, counter-stage model and frame-outcome reference model.
module tb_uart_rx_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       RX_IN = 1'b1;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic [5:0] Prescale = 6'd8;
   logic [5:0] edge_cnt;
   logic [3:0] bit_cnt;
   logic       cnt_enable;
`ifdef UART_RX_ERR_CNT_EN
   logic [7:0] err_cnt;
`endif

   uart_rx_ctrl_if #(.DATA_WIDTH(8)) rx_out ();

   uart_rx_ctrl dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_IN      (RX_IN),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .Prescale   (Prescale),
      .edge_cnt   (edge_cnt),
      .bit_cnt    (bit_cnt),
      .cnt_enable (cnt_enable),
`ifdef UART_RX_ERR_CNT_EN
      .err_cnt    (err_cnt),
`endif
      .rx_out     (rx_out)
   );

   always #5 CLK = ~CLK;

   // Edge/bit counter stage the controller drives.
   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         edge_cnt <= 6'd0;
         bit_cnt  <= 4'd0;
      end else if (!cnt_enable) begin
         edge_cnt <= 6'd0;
         bit_cnt  <= 4'd0;
      end else if (edge_cnt == Prescale - 6'd1) begin
         edge_cnt <= 6'd0;
         bit_cnt  <= bit_cnt + 4'd1;
      end else begin
         edge_cnt <= edge_cnt + 6'd1;
      end
   end

   logic [7:0] dv_q[$];
   logic [7:0] exp_q[$];

   // Every cycle with data_valid high records the word presented.
   always @(negedge CLK) begin
      if (RST && rx_out.data_valid) begin
         dv_q.push_back(rx_out.P_DATA);
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] m_pdata = 8'h00;
   logic       m_par   = 1'b0;
   logic       m_stp   = 1'b0;
   int         m_err   = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         RX_IN = 1'b1;
      end
   endtask

   task automatic driveBit(input logic v, input bit glitch);
      int p;
      p = int'(Prescale);
      for (int c = 0; c < p; c++) begin
         @(negedge CLK);
         RX_IN = (glitch && (c == p / 2 + 1)) ? ~v : v;
      end
   endtask

   task automatic applyStimulus(input logic [7:0] data, input logic par_bit, input logic stop_bit, input int glitch_idx);
      driveBit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         driveBit(data[i], i == glitch_idx);
      end
      if (PAR_EN) begin
         driveBit(par_bit, 1'b0);
      end
      driveBit(stop_bit, 1'b0);
   endtask

   // Frame outcome from the line-protocol rules alone.
   task automatic modelFrame(input logic [7:0] data, input logic par_bit, input logic stop_bit);
      logic pe;
      logic se;
      pe = PAR_EN && (par_bit != ((^data) ^ PAR_TYP));
      se = !stop_bit;
      m_par = pe;
      m_stp = se;
      if (!pe && !se) begin
         m_pdata = data;
         exp_q.push_back(data);
      end else if (m_err < 255) begin
         m_err++;
      end
   endtask

   task automatic modelReset();
      m_pdata = 8'h00;
      m_par   = 1'b0;
      m_stp   = 1'b0;
      m_err   = 0;
      dv_q.delete();
      exp_q.delete();
   endtask

   task automatic checkFrame(input string tag);
      int n;
      checkOutput({tag, "_pdata"}, rx_out.P_DATA, m_pdata);
      checkOutput({tag, "_par_err"}, rx_out.par_err, m_par);
      checkOutput({tag, "_stp_err"}, rx_out.stp_err, m_stp);
      checkOutput({tag, "_busy"}, rx_out.busy, 1'b0);
      checkOutput({tag, "_cnt_en"}, cnt_enable, 1'b0);
      checkOutput({tag, "_dv_count"}, dv_q.size(), exp_q.size());
      n = (dv_q.size() < exp_q.size()) ? dv_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         checkOutput({tag, "_dv_word"}, dv_q[i], exp_q[i]);
      end
`ifdef UART_RX_ERR_CNT_EN
      checkOutput({tag, "_err_cnt"}, err_cnt, m_err);
`endif
      dv_q.delete();
      exp_q.delete();
   endtask

   task automatic setCfg(input logic [5:0] p, input logic pen, input logic ptyp);
      Prescale = p;
      PAR_EN   = pen;
      PAR_TYP  = ptyp;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_pdata"}, rx_out.P_DATA, 8'h00);
      checkOutput({tag, "_dv"}, rx_out.data_valid, 1'b0);
      checkOutput({tag, "_par_err"}, rx_out.par_err, 1'b0);
      checkOutput({tag, "_stp_err"}, rx_out.stp_err, 1'b0);
      checkOutput({tag, "_busy"}, rx_out.busy, 1'b0);
      checkOutput({tag, "_cnt_en"}, cnt_enable, 1'b0);
`ifdef UART_RX_ERR_CNT_EN
      checkOutput({tag, "_err_cnt"}, err_cnt, 8'd0);
`endif
   endtask

   initial begin
      logic [7:0] d;
      logic       pb;
      logic       sb;
      int         gi;

      repeat (3) @(negedge CLK);
      checkAllZero("reset");
      RST = 1'b1;
      idle(4);

      // Prescale 8, no parity, with exact strobe timing.
      setCfg(6'd8, 1'b0, 1'b0);
      applyStimulus(8'hA5, 1'b0, 1'b1, 99);
      idle(1);
      checkOutput("lat_before", rx_out.data_valid, 1'b0);
      idle(1);
      checkOutput("lat_strobe", rx_out.data_valid, 1'b1);
      checkOutput("lat_pdata", rx_out.P_DATA, 8'hA5);
      idle(1);
      checkOutput("lat_after", rx_out.data_valid, 1'b0);
      idle(16);
      modelFrame(8'hA5, 1'b0, 1'b1);
      checkFrame("a5");

      // Prescale 16, even parity, good then bad parity.
      setCfg(6'd16, 1'b1, 1'b0);
      applyStimulus(8'h3C, 1'b0, 1'b1, 99);
      idle(40);
      modelFrame(8'h3C, 1'b0, 1'b1);
      checkFrame("par_ok");
      applyStimulus(8'h3C, 1'b1, 1'b1, 99);
      idle(40);
      modelFrame(8'h3C, 1'b1, 1'b1);
      checkFrame("par_bad");

      // Prescale 32, stop error then a good frame clearing flags at START.
      setCfg(6'd32, 1'b0, 1'b0);
      applyStimulus(8'h81, 1'b0, 1'b0, 99);
      idle(70);
      modelFrame(8'h81, 1'b0, 1'b0);
      checkFrame("stp_bad");
      fork
         applyStimulus(8'h55, 1'b0, 1'b1, 99);
         begin
            repeat (96) @(negedge CLK);
            checkOutput("start_clr_stp", rx_out.stp_err, 1'b0);
            checkOutput("start_clr_busy", rx_out.busy, 1'b1);
         end
      join
      idle(70);
      modelFrame(8'h55, 1'b0, 1'b1);
      checkFrame("after_stp");

      // Short low pulse on the line is rejected as a false start.
      setCfg(6'd16, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         RX_IN = 1'b0;
      end
      checkOutput("glitch_busy", rx_out.busy, 1'b1);
      idle(48);
      checkFrame("glitch_start");

      // Asynchronous reset in the middle of the data bits.
      setCfg(6'd8, 1'b0, 1'b0);
      driveBit(1'b0, 1'b0);
      driveBit(1'b1, 1'b0);
      driveBit(1'b1, 1'b0);
      driveBit(1'b0, 1'b0);
      #2;
      RST = 1'b0;
      #1;
      checkAllZero("mid_reset");
      idle(3);
      RST = 1'b1;
      modelReset();
      idle(4);
      applyStimulus(8'h0F, 1'b0, 1'b1, 99);
      idle(20);
      modelFrame(8'h0F, 1'b0, 1'b1);
      checkFrame("post_reset");

      // Back-to-back frames, each carrying a single-sample mid-bit glitch.
      applyStimulus(8'h12, 1'b0, 1'b1, 5);
      applyStimulus(8'h34, 1'b0, 1'b1, 3);
      idle(20);
      modelFrame(8'h12, 1'b0, 1'b1);
      modelFrame(8'h34, 1'b0, 1'b1);
      checkFrame("b2b");

      // Randomized frames against the reference model.
      for (int k = 0; k < 24; k++) begin
         case ($urandom_range(0, 2))
            0:       setCfg(6'd8,  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            1:       setCfg(6'd16, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            default: setCfg(6'd32, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         endcase
         d  = 8'($urandom);
         pb = (^d) ^ PAR_TYP;
         if ($urandom_range(0, 3) == 0) begin
            pb = ~pb;
         end
         sb = ($urandom_range(0, 3) != 0);
         gi = $urandom_range(0, 11);
         applyStimulus(d, pb, sb, gi);
         idle(2 * int'(Prescale) + 4);
         modelFrame(d, pb, sb);
         checkFrame("rand");
      end

`ifdef UART_RX_ERR_CNT_EN
      // Error counter saturation with parity-error frames.
      setCfg(6'd8, 1'b1, 1'b0);
      for (int k = 0; k < 300; k++) begin
         d = 8'($urandom);
         applyStimulus(d, ~(^d), 1'b1, 99);
         idle(3);
         modelFrame(d, ~(^d), 1'b1);
      end
      idle(8);
      checkOutput("err_sat", err_cnt, 8'd255);
      checkFrame("err_frames");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
